// File: rtl/button_gesture.sv
// Classifies debounced press/release events into short, long, double-click pulses.
// Define BUTTON_GESTURE_AUTO_REPEAT_EN to add auto-repeat pulses while held long.
module button_gesture #(
  parameter int LONG_PRDS   = 50000,
  parameter int DCLICK_PRDS = 25000,
  parameter int REPEAT_PRDS = 10000,
  parameter int CNT_W       = 16
) (
  input  logic clk_100K,
  input  logic rst_n,
  input  logic btnPress,
  input  logic btnRelease,
  output logic shortPress,
  output logic longPress,
  output logic doubleClick,
  output logic repeatPulse,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT2,
    HOLD,
    DC_HOLD
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRDS - 1);
  localparam logic [CNT_W-1:0] DCL_LAST  = CNT_W'(DCLICK_PRDS - 1);

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic short_q, short_d;
  logic long_q, long_d;
  logic dbl_q, dbl_d;
  logic busy_q, busy_d;
  logic press_ev, rel_ev;
  logic cnt_en;

  // Coincident press and release cancel each other out.
  assign press_ev = btnPress & ~btnRelease;
  assign rel_ev   = btnRelease & ~btnPress;

`ifdef BUTTON_GESTURE_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_PRDS - 1);
  logic rep_q, rep_d;
  assign repeatPulse = rep_q;
`else
  assign repeatPulse = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    short_d = 1'b0;
    long_d  = 1'b0;
    dbl_d   = 1'b0;
`ifdef BUTTON_GESTURE_AUTO_REPEAT_EN
    rep_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (press_ev) state_d = PRESS1;
      end
      PRESS1: begin
        if (rel_ev) begin
          state_d = WAIT2;
        end else if (cnt_q == LONG_LAST) begin
          state_d = HOLD;
          long_d  = 1'b1;
        end
      end
      WAIT2: begin
        if (press_ev) begin
          state_d = DC_HOLD;
          dbl_d   = 1'b1;
        end else if (cnt_q == DCL_LAST) begin
          state_d = IDLE;
          short_d = 1'b1;
        end
      end
      HOLD: begin
        if (rel_ev) begin
          state_d = IDLE;
        end
`ifdef BUTTON_GESTURE_AUTO_REPEAT_EN
        else if (cnt_q == REP_LAST) begin
          rep_d = 1'b1;
        end
`endif
      end
      DC_HOLD: begin
        if (rel_ev) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef BUTTON_GESTURE_AUTO_REPEAT_EN
  assign cnt_en = (state_q == PRESS1) | (state_q == WAIT2) |
                  (state_q == HOLD);
`else
  assign cnt_en = (state_q == PRESS1) | (state_q == WAIT2);
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
`ifdef BUTTON_GESTURE_AUTO_REPEAT_EN
    end else if (rep_d) begin
      cnt_d = '0;
`endif
    end else if (cnt_en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_100K or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      dbl_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      short_q <= short_d;
      long_q  <= long_d;
      dbl_q   <= dbl_d;
      busy_q  <= busy_d;
    end
  end

`ifdef BUTTON_GESTURE_AUTO_REPEAT_EN
  always_ff @(posedge clk_100K or negedge rst_n) begin
    if (!rst_n) rep_q <= 1'b0;
    else        rep_q <= rep_d;
  end
`endif

  assign shortPress  = short_q;
  assign longPress   = long_q;
  assign doubleClick = dbl_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_button_gesture.sv
// Scoreboard bench for button_gesture: timestamp reference model, directed
// gesture scenarios and randomized press/release traffic.
module tb_button_gesture;

  localparam int LONG = 20;
  localparam int DCL  = 10;
  localparam int REP  = 5;
`ifdef BUTTON_GESTURE_AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btnPress = 1'b0;
  logic btnRelease = 1'b0;
  logic shortPress, longPress, doubleClick, repeatPulse, busy;

  button_gesture #(
    .LONG_PRDS(LONG),
    .DCLICK_PRDS(DCL),
    .REPEAT_PRDS(REP),
    .CNT_W(16)
  ) dut (
    .clk_100K(clk),
    .rst_n(rst_n),
    .btnPress(btnPress),
    .btnRelease(btnRelease),
    .shortPress(shortPress),
    .longPress(longPress),
    .doubleClick(doubleClick),
    .repeatPulse(repeatPulse),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_i;
    logic [3:0] pul;
    logic       busy;
  } rec_t;

  rec_t sbq[$];
  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  bit mon_en = 1'b0;

  // Model: gesture phase plus the edge at which that phase began.
  int ph = 0;
  int t0 = 0;

  int n_sht = 0, n_lng = 0, n_dbl = 0, n_rep = 0;
  int at_sht = -1, at_lng = -1, at_dbl = -1, at_rep = -1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)",
               name, act, exp, edge_n);
    end
  endtask

  function automatic int total();
    return n_sht + n_lng + n_dbl + n_rep;
  endfunction

  task automatic model_step(input int k, input logic p, input logic r);
    rec_t e;
    logic pe, re;
    pe = p & ~r;
    re = r & ~p;
    e.pul = 4'b0000;
    case (ph)
      0: if (pe) begin ph = 1; t0 = k; end
      1: begin
        if (re) begin
          ph = 2; t0 = k;
        end else if (k - t0 == LONG) begin
          ph = 3; t0 = k; e.pul[1] = 1'b1;
        end
      end
      2: begin
        if (pe) begin
          ph = 4; e.pul[2] = 1'b1;
        end else if (k - t0 == DCL) begin
          ph = 0; e.pul[0] = 1'b1;
        end
      end
      3: begin
        if (re) ph = 0;
        else if (AUTO && ((k - t0) % REP == 0)) e.pul[3] = 1'b1;
      end
      default: if (re) ph = 0;
    endcase
    e.edge_i = k;
    e.busy = (ph != 0);
    sbq.push_back(e);
  endtask

  task automatic step(input logic p, input logic r);
    btnPress = p;
    btnRelease = r;
    model_step(edge_n + 1, p, r);
    @(posedge clk);
    edge_n++;
    mon_en = 1'b1;
    #1;
    btnPress = 1'b0;
    btnRelease = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  task automatic reset_pulse();
    rec_t e;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_out",
        {27'd0, repeatPulse, doubleClick, longPress, shortPress, busy}, 0);
    ph = 0;
    e.edge_i = edge_n + 1;
    e.pul = 4'b0000;
    e.busy = 1'b0;
    sbq.push_back(e);
    @(posedge clk);
    edge_n++;
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    logic [3:0] got;
    rec_t e;
    if (mon_en) begin
      got = {repeatPulse, doubleClick, longPress, shortPress};
      if (got[0]) begin n_sht++; at_sht = edge_n; end
      if (got[1]) begin n_lng++; at_lng = edge_n; end
      if (got[2]) begin n_dbl++; at_dbl = edge_n; end
      if (got[3]) begin n_rep++; at_rep = edge_n; end
      chk("onehot", int'($countones(got) <= 1), 1);
      if (sbq.size() == 0) begin
        chk("sb_empty", 0, 1);
      end else begin
        e = sbq.pop_front();
        chk("sb_edge", edge_n, e.edge_i);
        chk("sb_pulse", int'(got), int'(e.pul));
        chk("sb_busy", int'(busy), int'(e.busy));
      end
    end
  end

  initial begin
    int b, s0, o0, sel, hold, gap;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state",
        {27'd0, repeatPulse, doubleClick, longPress, shortPress, busy}, 0);
    rst_n = 1'b1;

    // Short press
    b = edge_n + 1; s0 = n_sht; o0 = n_lng + n_dbl + n_rep;
    step(1, 0); idle(4); step(0, 1); idle(15);
    chk("t1_short_at", at_sht, b + 15);
    chk("t1_short_n", n_sht - s0, 1);
    chk("t1_others", n_lng + n_dbl + n_rep - o0, 0);

    // Long press, optional repeats, silent release
    b = edge_n + 1; s0 = n_lng; o0 = n_sht + n_dbl; at_rep = -1;
    gap = n_rep;
    step(1, 0); idle(36); step(0, 1); idle(3);
    chk("t2_long_at", at_lng, b + 20);
    chk("t2_long_n", n_lng - s0, 1);
    chk("t2_rep_n", n_rep - gap, AUTO ? 3 : 0);
    chk("t2_rep_at", at_rep, AUTO ? b + 35 : -1);
    chk("t2_others", n_sht + n_dbl - o0, 0);
    chk("t2_busy", int'(busy), 0);

    // Double click
    b = edge_n + 1; s0 = n_dbl; o0 = n_sht + n_lng + n_rep;
    step(1, 0); idle(2); step(0, 1); idle(4); step(1, 0);
    idle(21); step(0, 1); idle(12);
    chk("t3_dbl_at", at_dbl, b + 8);
    chk("t3_dbl_n", n_dbl - s0, 1);
    chk("t3_others", n_sht + n_lng + n_rep - o0, 0);

    // Release exactly at the long-press timeout
    b = edge_n + 1; s0 = n_lng;
    step(1, 0); idle(19); step(0, 1); idle(12);
    chk("ba_short_at", at_sht, b + 30);
    chk("ba_long_n", n_lng - s0, 0);

    // Second press exactly at the double-click timeout
    b = edge_n + 1; s0 = n_sht;
    step(1, 0); step(0, 1); idle(9); step(1, 0); step(0, 1); idle(12);
    chk("bb_dbl_at", at_dbl, b + 11);
    chk("bb_short_n", n_sht - s0, 0);

    // Simultaneous and stray events in IDLE
    o0 = total();
    step(1, 1);
    chk("sim_busy", int'(busy), 0);
    step(0, 1);
    chk("rel_busy", int'(busy), 0);
    idle(3);
    chk("sim_pulses", total() - o0, 0);

    // Reset mid-PRESS1
    o0 = total();
    step(1, 0); idle(12);
    reset_pulse();
    chk("rst_busy", int'(busy), 0);
    step(0, 1); idle(30);
    chk("rst_no_pulse", total() - o0, 0);
    b = edge_n + 1;
    step(1, 0); idle(22);
    chk("rst_fresh_long", at_lng, b + 20);
    step(0, 1); idle(3);

    // Randomized traffic
    for (int g = 0; g < 200; g++) begin
      sel = $urandom_range(0, 24);
      if (sel == 0) begin
        reset_pulse();
      end else if (sel == 1) begin
        step(1, 1);
      end else if (sel == 2) begin
        step(0, 1);
      end else begin
        step(1, 0);
        hold = $urandom_range(1, 30);
        repeat (hold - 1) step($urandom_range(0, 15) == 0, 1'b0);
        if ($urandom_range(0, 19) == 0) reset_pulse();
        step(0, 1);
        gap = $urandom_range(0, 14);
        idle(gap);
      end
    end
    idle(LONG + DCL);

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    chk("sb_drain", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_gesture.md
Name: button_gesture

Overview:
- Downstream stage of the debounced button filter, clocked on the 100 kHz domain.
- Consumes the filter's single-cycle btnPress/btnRelease events and classifies them into single-cycle gesture pulses: short press, long press, double click and (optionally) auto-repeat.
- Feeds the SquareWave control logic, which steps frequency/duty settings from these gestures.

Parameters:
- LONG_PRDS, 50000, clk cycles a press must be held to count as long (500 ms).
- DCLICK_PRDS, 25000, clk cycles after a release in which a second press makes a double click (250 ms).
- REPEAT_PRDS, 10000, auto-repeat interval while held after a long press (100 ms).
- CNT_W, 16, counter width. Must satisfy 2^CNT_W > max(LONG_PRDS, DCLICK_PRDS, REPEAT_PRDS).

Ports:
- clk_100K  input  1  100 kHz system clock.
- rst_n  input  1  asynchronous, active-low reset.
- btnPress  input  1  single-cycle press event from the debounce filter.
- btnRelease  input  1  single-cycle release event from the debounce filter.
- shortPress  output  1  single-cycle pulse: short press with no second press.
- longPress  output  1  single-cycle pulse: press held LONG_PRDS cycles.
- doubleClick  output  1  single-cycle pulse: second press within the window.
- repeatPulse  output  1  single-cycle auto-repeat pulse (0 when feature is off).
- busy  output  1  level: FSM not in IDLE.

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE and the counter clears to 0.
  - All outputs are registered and reset to 0.
  - Reset mid-gesture abandons the gesture; no pulse is emitted.
- Counter: one shared CNT_W-bit counter.
  - Cleared to 0 on every state transition.
  - Increments by 1 per cycle in PRESS1, WAIT2 and HOLD; never wraps within a state.
- States and transitions:
  - IDLE: btnPress -> PRESS1. btnRelease is ignored.
  - PRESS1:
    - btnRelease -> WAIT2.
    - Else, when cnt == LONG_PRDS-1 -> HOLD, and longPress pulses.
  - HOLD: btnRelease -> IDLE, with no pulse on release. btnPress is ignored.
  - WAIT2:
    - btnPress -> DC_HOLD, and doubleClick pulses.
    - Else, when cnt == DCLICK_PRDS-1 -> IDLE, and shortPress pulses.
  - DC_HOLD: btnRelease -> IDLE. Never emits long or repeat pulses.
- Latency (edge E = the edge that samples the triggering input):
  - longPress is high for the one cycle after edge E+LONG_PRDS, where E sampled btnPress.
  - shortPress is high for the one cycle after edge E+DCLICK_PRDS, where E sampled btnRelease.
  - doubleClick is high for the one cycle after the edge that samples the second btnPress.
- Simultaneous events:
  - btnPress and btnRelease in the same cycle: both ignored, no state change.
  - An input event in the same cycle as a timeout: the event wins. Release at cnt == LONG_PRDS-1 gives the short path; press at cnt == DCLICK_PRDS-1 gives doubleClick.
- At most one of shortPress/longPress/doubleClick/repeatPulse is high in any cycle.
- busy = (state != IDLE), registered with the state.

Optional Feature:
- Macro: BUTTON_GESTURE_AUTO_REPEAT_EN.
- Defined:
  - In HOLD, when cnt == REPEAT_PRDS-1, repeatPulse pulses and cnt clears.
  - The first repeatPulse comes REPEAT_PRDS cycles after longPress.
  - Repeats continue until btnRelease.
- Undefined: repeatPulse is tied to 0. HOLD only waits for release, and its counter is held at 0.

Test Plan (LONG_PRDS=20, DCLICK_PRDS=10, REPEAT_PRDS=5):
- Press at edge 0, release at edge 5, no further press -> shortPress for one cycle after edge 15; no other pulses; busy=0 from edge 15.
- Press at edge 0, held -> longPress for one cycle after edge 20. With the macro defined: repeatPulse after edges 25, 30, 35 while held; release at edge 37 -> IDLE, no pulse.
- Press at edge 0, release at edge 3, press at edge 8 -> doubleClick after edge 8; release at edge 30 -> IDLE; no shortPress/longPress/repeatPulse.
- Boundaries:
  - Release exactly at cnt=19 in PRESS1 -> short path, not long.
  - Press exactly at cnt=9 in WAIT2 -> doubleClick, not shortPress.
- Press and release asserted in the same cycle while IDLE -> no state change, busy stays 0. Release alone in IDLE -> ignored.
- rst_n low for 1 cycle mid-PRESS1 at cnt=12 -> outputs 0, busy=0. Held release afterwards -> no pulse. A fresh press yields longPress after 20 edges.
